key_debounce2: RTL

KEY_DEBOUNCE2 -- requirements
Module: key_debounce2

---
 rtl/key_debounce2.sv | 123 ++++++++++++
 1 files changed

// File: rtl/key_debounce2.sv
// key_debounce2 -- dual push-button debouncer.
//
// Two identical, independent channels (A and B). Each channel accepts a new
// debounced level only after CNT_MAX consecutive samples that differ from the
// current debounced level; any shorter run is discarded. A one-cycle press
// flag accompanies every 0->1 transition of the debounced output.
//
// Optional feature: define KEY_DEBOUNCE2_SYNC_EN to insert a two-flop
// synchronizer (reset value 1 = released) in front of each filter. This adds
// two cycles of latency; without it the raw pins feed the filter directly.
//
// Parameters:
//   CNT_MAX    consecutive stable samples required to accept a change (2..2^24)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   pi_key_a   raw key A, active-low (0 = pressed), asynchronous to clk
//   pi_key_b   raw key B, active-low (0 = pressed), asynchronous to clk
//   po_a       debounced key A, active-high, registered
//   po_b       debounced key B, active-high, registered
//   po_a_flag  one-cycle press pulse for key A, registered
//   po_b_flag  one-cycle press pulse for key B, registered

module key_debounce2 #(
    parameter int unsigned CNT_MAX = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pi_key_a,
    input  logic pi_key_b,
    output logic po_a,
    output logic po_b,
    output logic po_a_flag,
    output logic po_b_flag
);

    localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic {
        STABLE,
        COUNTING
    } state_t;

    logic [1:0] key_raw;
    logic [1:0] key_flt;   // active-low level seen by the filters

    assign key_raw = {pi_key_b, pi_key_a};

`ifdef KEY_DEBOUNCE2_SYNC_EN
    logic [1:0] sync1;
    logic [1:0] sync2;

    // Reset to '1 so a held key after reset looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign key_flt = sync2;
`else
    assign key_flt = key_raw;
`endif

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic          deb_q;
        logic          flag_q;
        logic          sample;

        assign sample = ~key_flt[ch];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= STABLE;
                cnt    <= '0;
                deb_q  <= 1'b0;
                flag_q <= 1'b0;
            end else begin
                flag_q <= 1'b0;
                case (state)
                    STABLE: begin
                        if (sample != deb_q) begin
                            cnt   <= CW'(1);
                            state <= COUNTING;
                        end
                    end
                    COUNTING: begin
                        if (sample == deb_q) begin
                            // bounce back: discard the run
                            cnt   <= '0;
                            state <= STABLE;
                        end else if (cnt == CNT_LAST) begin
                            // CNT_MAX-th differing sample: accept new level
                            deb_q  <= sample;
                            flag_q <= sample;
                            cnt    <= '0;
                            state  <= STABLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= STABLE;
                    end
                endcase
            end
        end
    end

    assign po_a      = g_ch[0].deb_q;
    assign po_b      = g_ch[1].deb_q;
    assign po_a_flag = g_ch[0].flag_q;
    assign po_b_flag = g_ch[1].flag_q;

endmodule
